// File: rtl/uart_msg_pkg.sv
// Shared types and constants for the UART message controller:
// FSM state encoding and the default banner table.
package uart_msg_pkg;

  typedef enum logic [1:0] {IDLE, ECHO, MSG} state_t;

  localparam int unsigned MSG_LEN_DEF = 21;

  localparam logic [8*MSG_LEN_DEF-1:0] BANNER_DEF = {"Hello ALINX AX7101 ", 8'h0A, 8'h0D};

  // Byte used for banner positions beyond the default table.
  localparam logic [7:0] BANNER_FILL = 8'h20;

  function automatic logic [7:0] banner_byte(input int unsigned i);
    return BANNER_DEF[8*(MSG_LEN_DEF-1-i) +: 8];
  endfunction

endpackage

// File: rtl/uart_msg_if.sv
// Handshake bundle between the controller and its UART receiver/transmitter.
interface uart_msg_if;
  logic       rdsig;
  logic [7:0] rxdata;
  logic       txbusy;
  logic       msg_en;
  logic       wrsig;
  logic [7:0] dataout;
  logic       busy;
  logic       echo_ovf;

  modport master (output rdsig, rxdata, txbusy, msg_en,
                  input  wrsig, dataout, busy, echo_ovf);
  modport slave  (input  rdsig, rxdata, txbusy, msg_en,
                  output wrsig, dataout, busy, echo_ovf);
endinterface

// File: rtl/uart_msg_rom.sv
// Combinational banner ROM: message index to byte.
module uart_msg_rom
  import uart_msg_pkg::*;
#(
  parameter int unsigned MSG_LEN = MSG_LEN_DEF,
  parameter int unsigned IDX_W   = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       data
);

  always_comb begin
    data = BANNER_FILL;
    if (32'(idx) < MSG_LEN_DEF && 32'(idx) < MSG_LEN) data = banner_byte(32'(idx));
  end

endmodule

// File: rtl/uart_msg_ctrl.sv
// UART transmit-side controller: echoes received bytes through a FIFO and
// streams a banner after a receive-quiet interval, paced on txbusy and a gap.
module uart_msg_ctrl
  import uart_msg_pkg::*;
#(
  parameter int unsigned MSG_LEN    = MSG_LEN_DEF,
  parameter int unsigned IDLE_WAIT  = 262144,
  parameter int unsigned CHAR_GAP   = 255,
  parameter int unsigned ECHO_DEPTH = 8
) (
  input logic       clk,
  input logic       rst,
  uart_msg_if.slave bus
);

  localparam int unsigned IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int unsigned PTR_W = $clog2(ECHO_DEPTH);
  localparam int unsigned QW    = $clog2(IDLE_WAIT);
  localparam int unsigned GW    = (CHAR_GAP > 1) ? $clog2(CHAR_GAP) : 1;

  localparam logic [QW-1:0]    QUIET_MAX = QW'(IDLE_WAIT - 1);
  localparam logic [GW-1:0]    GAP_LOAD  = GW'(CHAR_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(MSG_LEN - 1);
  localparam logic [PTR_W:0]   PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [QW-1:0]    quiet;
  logic [GW-1:0]    gap;
  logic             wrsig_q, ovf_q;
  logic [7:0]       dout_q, send_byte, rom_byte, head;
  logic [7:0]       mem [ECHO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             empty, full, last_one, push, pop, send, start, breq, ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign last_one = ((wr_ptr - rd_ptr) == PTR_ONE);
  assign head     = mem[rd_ptr[PTR_W-1:0]];
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push     = bus.rdsig && (!full || pop);
  assign breq     = (quiet == QUIET_MAX);
  assign ok       = !bus.txbusy && (gap == '0);

  assign bus.wrsig    = wrsig_q;
  assign bus.dataout  = dout_q;
  assign bus.busy     = (state != IDLE);
  assign bus.echo_ovf = ovf_q;

  uart_msg_rom #(.MSG_LEN(MSG_LEN), .IDX_W(IDX_W)) u_rom (
    .idx  (idx),
    .data (rom_byte)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pop       = 1'b0;
    send      = 1'b0;
    start     = 1'b0;
    send_byte = head;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt = ECHO;
        end else if (breq && bus.msg_en) begin
          idx_nxt   = '0;
          start     = 1'b1;
          state_nxt = MSG;
        end
      end
      ECHO: begin
        if (empty) begin
          state_nxt = IDLE;
        end else if (ok) begin
          pop  = 1'b1;
          send = 1'b1;
          // A same-cycle push keeps the FIFO non-empty after this pop.
          if (last_one && !bus.rdsig) state_nxt = IDLE;
        end
      end
      MSG: begin
        if (!empty) begin
          idx_nxt   = '0;
          state_nxt = ECHO;
        end else if (ok) begin
          send      = 1'b1;
          send_byte = rom_byte;
          if (idx == IDX_LAST) begin
            idx_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      quiet   <= '0;
      gap     <= '0;
      wrsig_q <= 1'b0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      wrsig_q <= send;
      if (send) dout_q <= send_byte;
      if (send) gap <= GAP_LOAD;
      else if (gap != '0) gap <= gap - 1'b1;
      if (bus.rdsig || start) quiet <= '0;
      else if (!breq) quiet <= quiet + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (bus.rdsig && !push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= bus.rxdata;
  end

endmodule

// File: tb/tb_uart_msg_ctrl.sv
// Self-checking bench for uart_msg_ctrl: directed scenarios plus randomized
// echo traffic against a queue-based FIFO/banner reference model.
module tb_uart_msg_ctrl;

  localparam int MSG_LEN    = 21;
  localparam int IDLE_WAIT  = 64;
  localparam int CHAR_GAP   = 4;
  localparam int ECHO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   t_rd;
  string hello = "Hello ALINX AX7101 ";

  always #5 clk = ~clk;

  uart_msg_if bus ();

  uart_msg_ctrl #(
    .MSG_LEN    (MSG_LEN),
    .IDLE_WAIT  (IDLE_WAIT),
    .CHAR_GAP   (CHAR_GAP),
    .ECHO_DEPTH (ECHO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [7:0] exp_banner(input int i);
    if (i < hello.len()) return hello[i];
    else if (i == hello.len()) return 8'h0A;
    else return 8'h0D;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_pulse(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      if (bus.wrsig === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (bus.wrsig !== 1'b0) begin n_bad++; $display("FAIL rst_wrsig: got %b want 0", bus.wrsig); end
    n_cmp++; if (bus.dataout !== 8'h00) begin n_bad++; $display("FAIL rst_dataout: got %h want 00", bus.dataout); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.echo_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", bus.echo_ovf); end
    rst = 1'b0;
  endtask

  task automatic test_echo();
    bit got;
    bus.msg_en = 1'b1;
    tick();
    t_rd = cyc;
    bus.rdsig = 1'b1;
    bus.rxdata = 8'h5A;
    tick();
    bus.rdsig = 1'b0;
    wait_pulse(10, got);
    n_cmp++; if (!got || cyc != t_rd + 3) begin n_bad++; $display("FAIL echo_latency: got %0d want %0d", cyc - t_rd, 3); end
    n_cmp++; if (bus.dataout !== 8'h5A) begin n_bad++; $display("FAIL echo_data: got %h want 5a", bus.dataout); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL echo_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_banner();
    bit got;
    int last;
    wait_pulse(IDLE_WAIT + 20, got);
    bus.msg_en = 1'b0;
    n_cmp++; if (!got || cyc != t_rd + IDLE_WAIT + 2) begin n_bad++; $display("FAIL banner_start: got %0d want %0d", cyc - t_rd, IDLE_WAIT + 2); end
    n_cmp++; if (bus.dataout !== exp_banner(0)) begin n_bad++; $display("FAIL banner_b0: got %h want %h", bus.dataout, exp_banner(0)); end
    last = cyc;
    for (int i = 1; i < MSG_LEN; i++) begin
      wait_pulse(20, got);
      n_cmp++; if (!got || cyc - last != CHAR_GAP) begin n_bad++; $display("FAIL banner_gap%0d: got %0d want %0d", i, cyc - last, CHAR_GAP); end
      n_cmp++; if (bus.dataout !== exp_banner(i)) begin n_bad++; $display("FAIL banner_b%0d: got %h want %h", i, bus.dataout, exp_banner(i)); end
      last = cyc;
    end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL banner_busy_end: got %b want 0", bus.busy); end
  endtask

  task automatic test_abort();
    bit got;
    int t5;
    bus.msg_en = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      wait_pulse(30, got);
      n_cmp++; if (!got || bus.dataout !== exp_banner(i)) begin n_bad++; $display("FAIL abort_pre_b%0d: got %h want %h", i, bus.dataout, exp_banner(i)); end
    end
    t5 = cyc;
    bus.rdsig = 1'b1;
    bus.rxdata = 8'h31;
    tick();
    bus.rdsig = 1'b0;
    wait_pulse(20, got);
    n_cmp++; if (!got || cyc != t5 + CHAR_GAP) begin n_bad++; $display("FAIL abort_echo_time: got %0d want %0d", cyc - t5, CHAR_GAP); end
    n_cmp++; if (bus.dataout !== 8'h31) begin n_bad++; $display("FAIL abort_echo_data: got %h want 31", bus.dataout); end
    wait_pulse(IDLE_WAIT + 20, got);
    bus.msg_en = 1'b0;
    n_cmp++; if (!got || cyc != t5 + IDLE_WAIT + 2) begin n_bad++; $display("FAIL abort_restart_time: got %0d want %0d", cyc - t5, IDLE_WAIT + 2); end
    n_cmp++; if (bus.dataout !== exp_banner(0)) begin n_bad++; $display("FAIL abort_restart_b0: got %h want %h", bus.dataout, exp_banner(0)); end
    for (int i = 0; i < 200 && bus.busy === 1'b1; i++) tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_drain: got busy %b want 0", bus.busy); end
  endtask

  task automatic test_overflow();
    logic [7:0] q[$];
    logic [7:0] b;
    bit got;
    int extra;
    bus.msg_en = 1'b0;
    bus.txbusy = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      bus.rdsig = 1'b1;
      bus.rxdata = b;
      if (i < ECHO_DEPTH) q.push_back(b);
      tick();
      if (i == ECHO_DEPTH - 1) begin
        n_cmp++; if (bus.echo_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b want 0", bus.echo_ovf); end
      end
    end
    bus.rdsig = 1'b0;
    tick();
    n_cmp++; if (bus.echo_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", bus.echo_ovf); end
    bus.txbusy = 1'b0;
    for (int i = 0; i < ECHO_DEPTH; i++) begin
      wait_pulse(20, got);
      b = q.pop_front();
      n_cmp++; if (!got || bus.dataout !== b) begin n_bad++; $display("FAIL ovf_echo%0d: got %h want %h", i, bus.dataout, b); end
    end
    extra = 0;
    repeat (30) begin tick(); if (bus.wrsig === 1'b1) extra++; end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL ovf_extra: got %0d pulses want 0", extra); end
    n_cmp++; if (bus.echo_ovf !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL ovf_final: got ovf %b busy %b want 1 0", bus.echo_ovf, bus.busy); end
  endtask

  task automatic test_pacing();
    bit got;
    int last, h, left, want;
    left = 0;
    h = 0;
    last = 0;
    bus.msg_en = 1'b1;
    for (int i = 0; i < MSG_LEN; i++) begin
      got = 1'b0;
      for (int w = 0; w < 80 && !got; w++) begin
        tick();
        if (left > 0) begin left--; if (left == 0) bus.txbusy = 1'b0; end
        if (bus.wrsig === 1'b1) got = 1'b1;
      end
      bus.msg_en = 1'b0;
      want = (h + 1 > CHAR_GAP) ? h + 1 : CHAR_GAP;
      n_cmp++; if (!got || bus.dataout !== exp_banner(i)) begin n_bad++; $display("FAIL pace_b%0d: got %h want %h", i, bus.dataout, exp_banner(i)); end
      if (i > 0) begin
        n_cmp++; if (cyc - last != want) begin n_bad++; $display("FAIL pace_gap%0d: got %0d want %0d", i, cyc - last, want); end
      end
      last = cyc;
      h = $urandom_range(0, 25);
      left = h;
      bus.txbusy = (h > 0);
    end
    while (left > 0) begin tick(); left--; end
    bus.txbusy = 1'b0;
    tick();
  endtask

  task automatic test_random_echo();
    logic [7:0] q[$];
    logic [7:0] b;
    bit rd_prev, tb_prev;
    int last;
    bus.msg_en = 1'b0;
    rd_prev = 1'b0;
    tb_prev = 1'b0;
    last = -100;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (bus.wrsig === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL rnd_pop: got %h want nothing", bus.dataout);
        end else begin
          b = q.pop_front();
          if (bus.dataout !== b) begin n_bad++; $display("FAIL rnd_data: got %h want %h", bus.dataout, b); end
        end
        n_cmp++; if (tb_prev || cyc - last < CHAR_GAP) begin n_bad++; $display("FAIL rnd_pacing: got gap %0d txbusy %b want >=%0d and 0", cyc - last, tb_prev, CHAR_GAP); end
        last = cyc;
      end
      if (rd_prev && q.size() < ECHO_DEPTH) q.push_back(bus.rxdata);
      if (k < 300) begin
        bus.rdsig  = ($urandom_range(0, 2) == 0);
        bus.rxdata = 8'($urandom);
        bus.txbusy = ($urandom_range(0, 3) == 0);
      end else begin
        bus.rdsig  = 1'b0;
        bus.txbusy = 1'b0;
      end
      rd_prev = bus.rdsig;
      tb_prev = bus.txbusy;
    end
    n_cmp++; if (q.size() != 0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rnd_drain: got %0d left busy %b want 0 0", q.size(), bus.busy); end
  endtask

  task automatic test_reset_mid();
    bit got;
    int pulses, busy_seen;
    bus.msg_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_pulse(IDLE_WAIT + 40, got);
      n_cmp++; if (!got || bus.dataout !== exp_banner(i)) begin n_bad++; $display("FAIL rmid_b%0d: got %h want %h", i, bus.dataout, exp_banner(i)); end
    end
    rst = 1'b1;
    bus.msg_en = 1'b0;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.wrsig !== 1'b0) begin n_bad++; $display("FAIL rmid_wrsig: got %b want 0", bus.wrsig); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.echo_ovf !== 1'b0) begin n_bad++; $display("FAIL rmid_ovf: got %b want 0", bus.echo_ovf); end
    pulses = 0;
    busy_seen = 0;
    repeat (IDLE_WAIT + 40) begin
      tick();
      if (bus.wrsig === 1'b1) pulses++;
      if (bus.busy === 1'b1) busy_seen++;
    end
    n_cmp++; if (pulses != 0 || busy_seen != 0) begin n_bad++; $display("FAIL rmid_quiet: got %0d pulses %0d busy want 0 0", pulses, busy_seen); end
  endtask

  initial begin
    rst        = 1'b1;
    bus.rdsig  = 1'b0;
    bus.rxdata = 8'h00;
    bus.txbusy = 1'b0;
    bus.msg_en = 1'b0;
    test_reset();
    test_echo();
    test_banner();
    test_abort();
    test_overflow();
    test_pacing();
    test_random_echo();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_msg_ctrl.md
# uart_msg_ctrl

Parametrised UART transmit-side controller that sits between the UART receiver and transmitter. It echoes every received byte through a small FIFO and, after a programmable quiet interval with no receive traffic, streams a fixed banner message. Unlike the fixed-count predecessor, it paces bytes on transmitter busy plus a minimum gap, never drops echo bytes while a banner is in flight, and aborts the banner only at byte boundaries.

## Interface
Parameters:
- MSG_LEN, 21: banner length in bytes, ≥1.
- IDLE_WAIT, 262144: receive-quiet cycles before a banner starts, ≥2.
- CHAR_GAP, 255: minimum cycles from one wrsig pulse to the next, ≥1.
- ECHO_DEPTH, 8: echo FIFO depth, power of two, ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- rdsig  in  1  one-cycle pulse, rxdata valid.
- rxdata  in  8  received byte.
- txbusy  in  1  high while the transmitter is shifting a byte.
- msg_en  in  1  enables periodic banner; sampled at banner start only.
- wrsig  out  1  one-cycle pulse, transmit dataout.
- dataout  out  8  byte to transmit; held until the next wrsig.
- busy  out  1  high in any state other than IDLE.
- echo_ovf  out  1  sticky; set when a byte is dropped on a full FIFO.

## Operation
- Reset: state IDLE; FIFO empty; quiet counter 0; gap counter 0 (gap satisfied); banner index 0. Outputs wrsig=0, dataout=8'h00, busy=0, echo_ovf=0.
- Echo FIFO: rdsig pushes rxdata. If the FIFO is full, the byte is dropped and echo_ovf is set. A pop and a push in the same cycle on a full FIFO accepts the push. echo_ovf clears only on rst.
- Quiet counter: cleared on rdsig; otherwise it increments and saturates at IDLE_WAIT-1. Reaching IDLE_WAIT-1 raises banner request `breq`. The counter clears when a banner starts.
- Send eligibility `ok` = !txbusy && gap counter done.
- States:
  - IDLE: if the FIFO is non-empty, go to ECHO. Otherwise, if breq && msg_en, clear the index and go to MSG. Echo has priority.
  - ECHO: when ok, pop the FIFO head, drive dataout, pulse wrsig, and load the gap counter. Stay while the FIFO is non-empty; return to IDLE when it is empty after the pop.
  - MSG: when ok, send banner[index], pulse wrsig, load the gap counter, and increment the index. After sending byte MSG_LEN-1, go to IDLE. If the FIFO is non-empty at a byte boundary (before the next send), abort to ECHO and reset the index to 0. A banner is never resumed mid-message; the next banner restarts at byte 0.
- Gap counter counts down from CHAR_GAP-1 after each wrsig. It is done at 0.
- Banner content (MSG_LEN=21): "Hello ALINX AX7101 " followed by 8'h0A, 8'h0D. For other MSG_LEN values, the content comes from the ROM sub-module.
- Index width is $clog2(MSG_LEN) (min 1). The index never exceeds MSG_LEN-1.

## Timing
- The decision cycle (state ∧ ok) registers wrsig=1 and dataout together. Both are visible the next cycle, and wrsig lasts exactly one cycle.
- Echo latency: rdsig at cycle t with IDLE, empty FIFO, ok → wrsig at t+3 (push t+1, state→ECHO t+2, pulse t+3).
- Consecutive wrsig pulses are ≥ max(CHAR_GAP, txbusy release) cycles apart.
- The banner starts IDLE_WAIT+2 cycles after the last rdsig, assuming idle.
- rst mid-byte deasserts wrsig on the next edge. No partial outputs survive, and the FIFO contents are discarded.
- rdsig coincident with a banner-byte decision: that byte is still sent, and the abort happens at the next boundary.

## Structure
- Package uart_msg_pkg holds the state enum (IDLE, ECHO, MSG), the default banner byte constants, and the MSG_LEN default.
- Sub-module uart_msg_rom: combinational index→byte, parametrised by MSG_LEN.
- The FIFO is inline: a register array with rd/wr pointers one bit wider than $clog2(ECHO_DEPTH).

## Test plan
- Quiet banner: IDLE_WAIT=64, CHAR_GAP=4, txbusy=0, no rx → 21 wrsig pulses 4 cycles apart, bytes 0x48 … 0x0A, 0x0D; busy drops after the last byte.
- Echo: rdsig with 0x5A from idle → wrsig at +3 with dataout=0x5A; the quiet counter restarts.
- Abort: rdsig with 0x31 while the banner is at index 5 → byte 5 completes, the next wrsig carries 0x31, and the following banner starts at 'H'.
- Overflow: ECHO_DEPTH=4, txbusy held high, 5 rdsig bytes → echo_ovf=1; after txbusy drops, exactly the first 4 bytes echo in order.
- Pacing: txbusy high for 20 cycles after each wrsig, CHAR_GAP=4 → pulses spaced by the txbusy release, not by 4.
- Reset mid-banner at index 10 → wrsig=0, busy=0, echo_ovf=0 the next cycle; with msg_en=0 no banner appears after the IDLE_WAIT interval.
